// File: rtl/capture_register_bank_if.sv
// Write-side handshake bundle for capture_register_bank: producer offers a word, sink accepts.
// Ports: DataInReg (write data), inValid (producer offers word), inReady (sink can accept).
// master = producer side, slave = capture bank side.
interface capture_register_bank_if #(
    parameter int DATAWIDTH = 8
) ();
    logic [DATAWIDTH-1:0] DataInReg;
    logic                 inValid;
    logic                 inReady;

    modport master (
        output DataInReg,
        output inValid,
        input  inReady
    );

    modport slave (
        input  DataInReg,
        input  inValid,
        output inReady
    );
endinterface

// File: rtl/capture_register_bank.sv
// Register sink: stores handshaked words in arrival order into DEPTH entries, tracks fill count and running max.
// Latency: accepted word shows in count/maxVal after the accepting edge; read-back is registered, 1 cycle from rdAddr.
// Backpressure: inReady drops once the bank is FULL or while clear is high; only clear re-opens the bank.
// Ports: clk, lowRst (async active-low), clear (sync flush), wr (slave handshake), rdAddr, DataOutReg,
//        count, maxVal, full, done (one-cycle pulse after the filling edge).
module capture_register_bank #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int ADDRWIDTH = 2
) (
    input  logic                 clk,
    input  logic                 lowRst,
    input  logic                 clear,
    capture_register_bank_if.slave wr,
    input  logic [ADDRWIDTH-1:0] rdAddr,
    output logic [DATAWIDTH-1:0] DataOutReg,
    output logic [ADDRWIDTH:0]   count,
    output logic [DATAWIDTH-1:0] maxVal,
    output logic                 full,
    output logic                 done
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [ADDRWIDTH:0] LAST_CNT = (ADDRWIDTH+1)'(DEPTH - 1);

    state_t               state;
    logic [DATAWIDTH-1:0] bank [DEPTH];
    logic                 accept;

    // Ready never looks at inValid, so a producer may wait on it before asserting valid.
    assign wr.inReady = (state != FULL) && !clear;
    assign accept     = wr.inValid && wr.inReady;
    assign full       = (state == FULL);

    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            state      <= EMPTY;
            count      <= '0;
            maxVal     <= '0;
            DataOutReg <= '0;
            done       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            // Non-blocking read: a same-edge write to the same index returns the old word.
            DataOutReg <= bank[rdAddr];
            done       <= 1'b0;
            if (clear) begin
                // Bank contents are deliberately kept; only bookkeeping is flushed.
                state  <= EMPTY;
                count  <= '0;
                maxVal <= '0;
            end else if (accept) begin
                bank[count[ADDRWIDTH-1:0]] <= wr.DataInReg;
                count <= count + 1'b1;
                if (wr.DataInReg > maxVal) begin
                    maxVal <= wr.DataInReg;
                end
                if (count == LAST_CNT) begin
                    state <= FULL;
                    done  <= 1'b1;
                end else begin
                    state <= FILLING;
                end
            end
        end
    end

endmodule

// File: doc/capture_register_bank.md
# capture_register_bank

Register sink that receives words over a valid/ready handshake and stores them in a small bank of DEPTH registers. It tracks the fill count and the running maximum, and gives registered random-access read-back. It is the receiving counterpart of the constant-source register in the sorting datapath: a producer writes words in, and the sorter or a debug path reads them back by index.

## Interface
- DATAWIDTH, default 8: width of every stored word.
- DEPTH, default 4: number of bank entries; must be a power of two, ≥ 2.
- ADDRWIDTH, default 2: log2(DEPTH).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- lowRst  input  1  reset; asynchronous, active-low.
- clear  input  1  synchronous flush of count, state and max; bank contents kept.
- DataInReg  input  DATAWIDTH  write data.
- inValid  input  1  producer offers DataInReg this cycle.
- inReady  output  1  block can accept a word this cycle.
- rdAddr  input  ADDRWIDTH  read index.
- DataOutReg  output  DATAWIDTH  registered read data for rdAddr.
- count  output  ADDRWIDTH+1  number of stored words, 0..DEPTH.
- maxVal  output  DATAWIDTH  largest word accepted since the last reset or clear.
- full  output  1  count == DEPTH.
- done  output  1  one-cycle pulse on the cycle the bank becomes full.

## Operation
- FSM states are EMPTY, FILLING and FULL.
- Reset (lowRst=0) forces the following immediately, without a clock:
  - state EMPTY;
  - all bank entries 0;
  - count 0, maxVal 0, DataOutReg 0, done 0.
- inReady = (state != FULL) && !clear. It is combinational from state and clear only, never from inValid.
- Accept rule: a word is accepted when inValid && inReady at a rising edge.
  - bank[count[ADDRWIDTH-1:0]] ← DataInReg.
  - count ← count+1.
  - maxVal ← max(maxVal, DataInReg), unsigned compare.
- Transitions:
  - EMPTY → FILLING on accept when DEPTH > 1.
  - FILLING stays in FILLING on accept while count+1 < DEPTH.
  - FILLING → FULL on the accept that makes count+1 == DEPTH. done=1 on the following cycle only.
  - FULL holds until clear. inValid is ignored and nothing is written.
  - clear=1 in any state → EMPTY, count 0, maxVal 0 on the next edge. clear has priority over a simultaneous inValid: no write, inReady is already 0.
- Words are stored in arrival order at indices 0..DEPTH-1. The index wraps only through clear, never by overflow.
- Read: DataOutReg ← bank[rdAddr] every cycle, independent of state.
  - Same-edge write and read to the same index returns the old contents.
  - Reading an index ≥ count returns stale or zero data. This is legal, not an error.
- full is combinational from state (state == FULL).
- count is a register; it never exceeds DEPTH.
- maxVal is a register.

## Timing
- Write latency: a word accepted at edge N is visible in count and maxVal after edge N.
  - It is readable on DataOutReg after edge N+1 when rdAddr selects it.
- Read latency: 1 cycle from rdAddr to DataOutReg.
- done is asserted exactly one cycle, in the cycle after the filling edge. full rises in the same cycle and stays high.
- Back-to-back accepts are allowed every cycle: full throughput until FULL.
- Reset asserted mid-fill clears everything asynchronously.
  - After deassertion the block is in EMPTY with inReady=1.
  - Nothing is written on the deassertion edge.
- A clear pulse while FULL gives inReady=0 in the clear cycle and inReady=1 on the next cycle.

## Test plan
- Reset values: hold lowRst=0 with clk running → DataOutReg=0, count=0, maxVal=0, full=0, done=0, inReady=1. After release, read rdAddr=0..3 → all 0.
- Fill and read back (DEPTH=4): write 0x12, 0x7F, 0x03, 0x40 on consecutive cycles.
  - count steps 1..4; done pulses once after the 4th write; full=1; inReady=0; maxVal=0x7F.
  - Reading rdAddr=0..3 → 0x12, 0x7F, 0x03, 0x40, each one cycle after the address.
- Overflow attempt: while FULL, drive inValid=1 with 0xFF for 3 cycles → count stays 4, bank unchanged, maxVal stays 0x7F, no done.
- Clear with simultaneous valid: clear=1 and inValid=1 with 0x55 in one cycle.
  - Result: count=0, maxVal=0, state EMPTY, 0x55 not stored.
  - Next cycle, write 0x09 → bank[0]=0x09, count=1, maxVal=0x09.
- Gapped producer: toggle inValid 1,0,1,0 with data 0x01, 0x02 (on the invalid cycles), 0x03, 0x04 (on the invalid cycles) → count=2, bank[0]=0x01, bank[1]=0x03.
- Async reset mid-fill: after 2 accepted writes, pulse lowRst low between clock edges → outputs drop to 0 before the next edge. The next write lands at index 0.
